// File: rtl/lut_table_loader_if.sv
// Bundle between the LUT table loader and its surroundings: the incoming
// word stream (valid/ready) and the table's row-parallel write/read port.
// The master modport is the loader; the slave modport is the stream source
// together with the table.
interface lut_table_loader_if #(
  parameter int WORDS = 4,
  parameter int AW    = 6
) ();
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;
  logic          tbl_en_write;
  logic          tbl_en_read;
  logic [AW-1:0] tbl_base;
  logic [31:0]   tbl_wdata [0:WORDS-1];
  logic [31:0]   tbl_rdata [0:WORDS-1];

  modport master (
    input  s_valid, s_data, tbl_rdata,
    output s_ready, tbl_en_write, tbl_en_read, tbl_base, tbl_wdata
  );

  modport slave (
    output s_valid, s_data, tbl_rdata,
    input  s_ready, tbl_en_write, tbl_en_read, tbl_base, tbl_wdata
  );
endinterface

// File: rtl/lut_table_loader.sv
// LUT table loader: packs a 32-bit word stream into WORDS-wide rows and
// writes ROWS rows into the SR-LUT table starting at base 0, then pulses done.
// Optional read-back check compiled in with macro LUT_LOADER_VERIFY_EN:
// each written row is read back, and the first mismatching row is latched
// in err_row with a sticky err flag.
// tbl_base and tbl_wdata are registered and only move on a stream handshake,
// so they are stable around every write/read strobe (the table is
// level-sensitive).
module lut_table_loader #(
  parameter int ROWS  = 36,
  parameter int WORDS = 4,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  lut_table_loader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AW-1:0]     err_row
);

  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [AW-1:0] LAST_ROW  = AW'(ROWS - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);

`ifdef LUT_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    CMP   = 3'd4,
    DONE  = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;
`endif

  state_t        state;
  logic [AW-1:0] row;
  logic [WW-1:0] word;
  logic          s_ready_q;
  logic          en_write_q;
  logic [AW-1:0] base_q;
  logic [31:0]   wdata_q [0:WORDS-1];
  logic          busy_q;
  logic          done_q;

`ifdef LUT_LOADER_VERIFY_EN
  logic          en_read_q;
  logic          err_q;
  logic [AW-1:0] err_row_q;
  logic          mismatch;

  // Any word of the read-back row differing from what was written flags the row.
  always_comb begin
    mismatch = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      if (bus.tbl_rdata[k] != wdata_q[k]) mismatch = 1'b1;
    end
  end
`endif

  // Load sequencer: stream fill, row write, optional read-back, row advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      word       <= '0;
      s_ready_q  <= 1'b0;
      en_write_q <= 1'b0;
      base_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int k = 0; k < WORDS; k++) wdata_q[k] <= '0;
`ifdef LUT_LOADER_VERIFY_EN
      en_read_q  <= 1'b0;
      err_q      <= 1'b0;
      err_row_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row       <= '0;
            word      <= '0;
            busy_q    <= 1'b1;
            s_ready_q <= 1'b1;
            state     <= FILL;
`ifdef LUT_LOADER_VERIFY_EN
            err_q     <= 1'b0;
            err_row_q <= '0;
`endif
          end
        end
        FILL: begin
          // Base follows the row on the first handshake, so it never moves
          // in the cycle right after a strobe.
          if (bus.s_valid && s_ready_q) begin
            wdata_q[word] <= bus.s_data;
            base_q        <= row;
            word          <= word + 1'b1;
            if (word == LAST_WORD) begin
              s_ready_q  <= 1'b0;
              en_write_q <= 1'b1;
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          en_write_q <= 1'b0;
`ifdef LUT_LOADER_VERIFY_EN
          en_read_q  <= 1'b1;
          state      <= READ;
`else
          if (row == LAST_ROW) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            row       <= row + 1'b1;
            word      <= '0;
            s_ready_q <= 1'b1;
            state     <= FILL;
          end
`endif
        end
`ifdef LUT_LOADER_VERIFY_EN
        READ: begin
          en_read_q <= 1'b0;
          state     <= CMP;
        end
        CMP: begin
          // Only the first bad row of a load is remembered.
          if (mismatch && !err_q) begin
            err_q     <= 1'b1;
            err_row_q <= row;
          end
          if (row == LAST_ROW) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            row       <= row + 1'b1;
            word      <= '0;
            s_ready_q <= 1'b1;
            state     <= FILL;
          end
        end
`endif
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready      = s_ready_q;
  assign bus.tbl_en_write = en_write_q;
  assign bus.tbl_base     = base_q;
  assign bus.tbl_wdata    = wdata_q;
  assign busy             = busy_q;
  assign done             = done_q;

`ifdef LUT_LOADER_VERIFY_EN
  assign bus.tbl_en_read  = en_read_q;
  assign err              = err_q;
  assign err_row          = err_row_q;
`else
  assign bus.tbl_en_read  = 1'b0;
  assign err              = 1'b0;
  assign err_row          = '0;
`endif

endmodule

// File: tb/tb_lut_table_loader.sv
// Testbench for lut_table_loader: behavioural table model plus a table of
// load scenarios, and hand-written reset sequences.
// Works in both the default build and with LUT_LOADER_VERIFY_EN defined.
module tb_lut_table_loader;

  localparam int ROWS  = 36;
  localparam int WORDS = 4;
  localparam int AW    = 6;
  localparam int NWORD = ROWS * WORDS;

`ifdef LUT_LOADER_VERIFY_EN
  localparam int  CYC_CONT = 253;
  localparam int  CYC_BP   = 397;
  localparam bit  VERIFY   = 1'b1;
`else
  localparam int  CYC_CONT = 181;
  localparam int  CYC_BP   = 325;
  localparam bit  VERIFY   = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] err_row;

  lut_table_loader_if #(.WORDS(WORDS), .AW(AW)) bus ();

  lut_table_loader #(.ROWS(ROWS), .WORDS(WORDS), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_row (err_row)
  );

  always #5 clk = ~clk;

  // Table model and strobe log
  logic [31:0]   mem [0:255] = '{default: 32'h0};
  logic [AW-1:0] wr_base [0:255];
  int            wr_cyc  [0:255];
  logic [AW-1:0] rd_base [0:255];
  int            rd_cyc  [0:255];
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  int            cyc = 0;
  bit            corrupt_en = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tbl_en_write) begin
      wr_base[wr_cnt] <= bus.tbl_base;
      wr_cyc[wr_cnt]  <= cyc;
      wr_cnt          <= wr_cnt + 1;
      for (int k = 0; k < WORDS; k++) mem[int'(bus.tbl_base) * WORDS + k] <= bus.tbl_wdata[k];
    end
    if (bus.tbl_en_read) begin
      rd_base[rd_cnt] <= bus.tbl_base;
      rd_cyc[rd_cnt]  <= cyc;
      rd_cnt          <= rd_cnt + 1;
    end
  end

  // Read port echoes stored words; entries 30 (row 7) and 81 (row 20) can be corrupted.
  always_comb begin
    for (int k = 0; k < WORDS; k++) begin
      int idx;
      idx = int'(bus.tbl_base) * WORDS + k;
      bus.tbl_rdata[k] = mem[idx] ^ ((corrupt_en && (idx == 30 || idx == 81)) ? 32'h0000_0100 : 32'h0);
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    int wbad;
    wbad = 0;
    for (int k = 0; k < WORDS; k++) if (bus.tbl_wdata[k] !== 32'h0) wbad++;
    chk({tag, "_s_ready"},  64'(bus.s_ready), 64'd0);
    chk({tag, "_en_write"}, 64'(bus.tbl_en_write), 64'd0);
    chk({tag, "_en_read"},  64'(bus.tbl_en_read), 64'd0);
    chk({tag, "_base"},     64'(bus.tbl_base), 64'd0);
    chk({tag, "_wdata_nz"}, 64'(wbad), 64'd0);
    chk({tag, "_busy"},     64'(busy), 64'd0);
    chk({tag, "_done"},     64'(done), 64'd0);
    chk({tag, "_err"},      64'(err), 64'd0);
    chk({tag, "_err_row"},  64'(err_row), 64'd0);
  endtask

  // One load: mode 0 = continuous stream, mode 1 = stall cycle before each word
  // (and a junk valid word whenever the loader is not filling).
  task automatic run_load(input int mode, input logic [31:0] dbase, input int start_row,
                          output int n, output int stall_chg);
    int            idx;
    bit            phase;
    bit            acc;
    bit            snap;
    logic [AW-1:0] snap_base;
    logic [31:0]   snap_w [0:WORDS-1];
    idx = 0; phase = 1'b0; n = 0; stall_chg = 0;
    snap_base = '0;
    for (int k = 0; k < WORDS; k++) snap_w[k] = '0;
    start = 1'b1;
    while (n < 2000) begin
      acc = 1'b0; snap = 1'b0;
      if (mode == 0) begin
        bus.s_valid = (idx < NWORD);
        bus.s_data  = dbase + 32'(idx);
        acc = bus.s_ready && (idx < NWORD);
      end else if (!bus.s_ready) begin
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hDEAD_BEEF;
      end else if (!phase) begin
        bus.s_valid = 1'b0;
        bus.s_data  = 32'hDEAD_BEEF;
        phase = 1'b1;
        snap  = 1'b1;
        snap_base = bus.tbl_base;
        for (int k = 0; k < WORDS; k++) snap_w[k] = bus.tbl_wdata[k];
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = dbase + 32'(idx);
        acc   = 1'b1;
        phase = 1'b0;
      end
      tick();
      n++;
      start = 1'b0;
      if (acc) idx++;
      if (snap) begin
        if (bus.tbl_base !== snap_base) stall_chg++;
        for (int k = 0; k < WORDS; k++) if (bus.tbl_wdata[k] !== snap_w[k]) stall_chg++;
      end
      if (done) break;
      if (start_row >= 0 && bus.tbl_en_write && bus.tbl_base == AW'(start_row)) start = 1'b1;
    end
    bus.s_valid = 1'b0;
    start = 1'b0;
  endtask

  typedef struct {
    int            mode;
    logic [31:0]   dbase;
    int            start_row;
    bit            corrupt;
    int            exp_cyc;
    bit            exp_err;
    logic [AW-1:0] exp_err_row;
  } vec_t;

  vec_t vecs [0:3];

  task automatic run_vec(input int id, input vec_t v);
    int n, stall_chg, wr0, rd0, bad;
    string t;
    t = $sformatf("v%0d", id);
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    corrupt_en = v.corrupt;
    run_load(v.mode, v.dbase, v.start_row, n, stall_chg);
    chk({t, "_cycles"}, 64'(n), 64'(v.exp_cyc));
    chk({t, "_busy_at_done"}, 64'(busy), 64'd1);
    chk({t, "_err"}, 64'(err), 64'(v.exp_err));
    chk({t, "_err_row"}, 64'(err_row), 64'(v.exp_err_row));
    chk({t, "_stall_changes"}, 64'(stall_chg), 64'd0);
    for (int k = 0; k < WORDS; k++)
      chk($sformatf("%s_row35_w%0d", t, k), 64'(bus.tbl_wdata[k]), 64'(v.dbase + 32'(140 + k)));
    tick();
    chk({t, "_done_after"}, 64'(done), 64'd0);
    chk({t, "_busy_after"}, 64'(busy), 64'd0);
    chk({t, "_s_ready_after"}, 64'(bus.s_ready), 64'd0);
    chk({t, "_writes"}, 64'(wr_cnt - wr0), 64'(ROWS));
    bad = 0;
    for (int r = 0; r < ROWS; r++) if (wr_base[wr0 + r] !== AW'(r)) bad++;
    chk({t, "_base_seq_bad"}, 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < NWORD; i++) if (mem[i] !== v.dbase + 32'(i)) bad++;
    chk({t, "_table_bad"}, 64'(bad), 64'd0);
    if (VERIFY) begin
      chk({t, "_reads"}, 64'(rd_cnt - rd0), 64'(ROWS));
      bad = 0;
      for (int r = 0; r < ROWS; r++)
        if (rd_base[rd0 + r] !== AW'(r) || rd_cyc[rd0 + r] != wr_cyc[wr0 + r] + 1) bad++;
      chk({t, "_read_seq_bad"}, 64'(bad), 64'd0);
    end else begin
      chk({t, "_reads"}, 64'(rd_cnt - rd0), 64'd0);
    end
    corrupt_en = 1'b0;
  endtask

  initial begin
    int idx, guard, bad;
    vecs[0] = '{mode: 0, dbase: 32'h0000_0000, start_row: -1, corrupt: 1'b0,
                exp_cyc: CYC_CONT, exp_err: 1'b0, exp_err_row: '0};
    vecs[1] = '{mode: 1, dbase: 32'hA500_0000, start_row: -1, corrupt: 1'b0,
                exp_cyc: CYC_BP, exp_err: 1'b0, exp_err_row: '0};
    vecs[2] = '{mode: 0, dbase: 32'h1111_0000, start_row: 3, corrupt: 1'b1,
                exp_cyc: CYC_CONT, exp_err: VERIFY, exp_err_row: VERIFY ? AW'(7) : AW'(0)};
    vecs[3] = '{mode: 0, dbase: 32'h2222_0000, start_row: 10, corrupt: 1'b1,
                exp_cyc: CYC_CONT, exp_err: VERIFY, exp_err_row: VERIFY ? AW'(7) : AW'(0)};

    rst = 1'b1;
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 32'h0;
    repeat (3) tick();
    check_reset_values("por");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) run_vec(i, vecs[i]);

    // Reset during FILL of row 10 with two words taken; start in the same cycle must lose.
    idx = 0;
    guard = 0;
    start = 1'b1;
    while (idx < 42 && guard < 1000) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h3333_0000 + 32'(idx);
      if (bus.s_ready) idx++;
      tick();
      start = 1'b0;
      guard++;
    end
    chk("rst_reach_row10", 64'(idx), 64'd42);
    chk("rst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    check_reset_values("midrst");
    rst = 1'b0;
    start = 1'b0;
    bus.s_valid = 1'b0;
    tick();
    chk("rst_start_lost", 64'(busy), 64'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) if (mem[i] !== 32'h3333_0000 + 32'(i)) bad++;
    chk("rst_rows_kept_bad", 64'(bad), 64'd0);
    chk("rst_row10_untouched", 64'(mem[40]), 64'(32'h1111_0028));

    run_vec(3, vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
